instr_encoder_loader: RTL and testbench
=======================================

// Module: instr_encoder_loader
// PURPOSE
//  Program-load path for the single-cycle core: accepts decoded instruction fields over a valid/ready
//  handshake, packs them into 32-bit words in the format the control decoder consumes, and writes the
//  words into instruction memory at consecutive addresses. Used by the testbench/host loader before
//  the core is released from reset; rejects encodings the decoder does not implement.
// PARAMETERS
//  ADDR_W     32  width of mem_addr / base_addr
//  ADDR_STEP  4   address increment per written word (byte addressing)
//  CNT_W      8   width of count / written_count
// PORTS
//  clk            in   1       system clock; everything sampled on rising edge
//  reset          in   1       asynchronous, active-high; one clock domain only
//  start          in   1       1-cycle pulse: begin a load job (ignored unless idle)
//  base_addr      in   ADDR_W  first write address, latched on start
//  count          in   CNT_W   instructions to consume in this job, latched on start
//  in_valid       in   1       field bundle valid
//  in_ready       out  1       encoder can take a bundle (transfer = in_valid & in_ready)
//  in_kind        in   2       00 DP, 01 LDR, 10 STR, 11 B
//  in_cond        in   4       condition field -> word[31:28]
//  in_cmd         in   4       DP command: 0100 ADD, 0010 SUB, 0001 XOR, 1111 NOT
//  in_s           in   1       DP set-flags bit
//  in_i           in   1       DP Src2 is immediate
//  in_rn, in_rd   in   4 each  register fields
//  in_src2        in   12      DP Src2 / memory offset (imm12)
//  in_imm24       in   24      branch offset
//  mem_we         out  1       instruction-memory write strobe
//  mem_addr       out  ADDR_W  write address
//  mem_wdata      out  32      encoded word
//  busy           out  1       job in progress (state != IDLE)
//  done           out  1       1-cycle pulse at job end
//  err_illegal    out  1       sticky: at least one bundle in job was illegal
//  written_count  out  CNT_W   words actually written in current/last job
// BEHAVIOUR
//  Reset: state IDLE; in_ready, mem_we, busy, done, err_illegal = 0; mem_addr, mem_wdata, written_count = 0.
//  Reset mid-job aborts immediately (async); partially written memory is left as is.
//  Encoding: word = {cond, op[1:0], funct[5:0], rn, rd, src2}
//   DP : op=00, funct={in_i, in_cmd, in_s}
//   LDR: op=01, funct=011001 ; STR: op=01, funct=011000 (positive imm offset, no writeback)
//   B  : op=10, word[25:24]=10, word[23:0]=in_imm24 (rn/rd/src2 ignored)
//  Illegal: in_kind=DP with in_cmd outside {0100,0010,0001,1111}. in_kind=11 is B, never illegal.
//  FSM IDLE -> ACCEPT -> WRITE -> (ACCEPT | DONE) -> IDLE:
//   IDLE  : in_ready=0. start: latch base_addr, count; clear err_illegal, written_count.
//           count=0 -> DONE, else ACCEPT.
//   ACCEPT: in_ready=1. On transfer: register encoded word; remaining-=1.
//           Legal -> WRITE. Illegal -> set err_illegal, no write, address not advanced;
//           remaining=0 -> DONE, else stay in ACCEPT.
//   WRITE : mem_we=1 exactly one cycle with registered addr/word; then addr+=ADDR_STEP
//           (wraps modulo 2^ADDR_W), written_count+=1; remaining=0 -> DONE, else ACCEPT.
//   DONE  : done=1 for one cycle -> IDLE. busy=0 only in IDLE.
//  Throughput: max one word per 2 cycles. start while busy is ignored. in_valid outside ACCEPT
//  is ignored; the source must hold its bundle until transfer.
// STRUCTURE
//  instr_enc_pkg: kind enum, DP command constants, LDR/STR funct constants, op codes, state enum,
//   word field bit positions (shared with the decoder bench).
//  Sub-module instr_field_packer: purely combinational bundle -> {word[31:0], legal}.
//  Top level holds the FSM, address and remaining counters, and output registers.
// TESTING
//  1 ADD: base=0x100, count=1, DP I=1 cmd=0100 S=0 cond=E rn=2 rd=1 src2=005
//    -> one mem_we, addr 0x100, data 0xE2821005; done pulse; written_count=1.
//  2 Burst of 4 with in_valid held high: SUBS reg(rn=3 rd=3 src2=004), LDR R0,[R1,#8],
//    STR R0,[R1,#8], B imm24=0x10 -> 0xE0533004@0x100, 0xE5910008@0x104, 0xE5810008@0x108,
//    0xEA000010@0x10C; each mem_we exactly 1 cycle.
//  3 count=3, middle bundle DP cmd=1010 -> 2 writes at 0x100/0x104; err_illegal=1;
//    written_count=2; next start clears err_illegal.
//  4 count=0 -> done one cycle after start, no mem_we; start pulsed while busy -> no effect.
//  5 Assert reset during WRITE -> mem_we low asynchronously, busy=0, new job restarts cleanly.
//  6 base=0xFFFFFFFC, count=2 -> writes at 0xFFFFFFFC then 0x00000000 (wrap).

Source files
------------

// File: rtl/instr_enc_pkg.sv
// rtl/instr_enc_pkg.sv - shared encodings, field positions and FSM states for the instruction loader
package instr_enc_pkg;

    localparam int ADDR_W_DEF    = 32;
    localparam int ADDR_STEP_DEF = 4;
    localparam int CNT_W_DEF     = 8;

    typedef enum logic [1:0] {
        KIND_DP  = 2'b00,
        KIND_LDR = 2'b01,
        KIND_STR = 2'b10,
        KIND_B   = 2'b11
    } kind_e;

    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_XOR = 4'b0001;
    localparam logic [3:0] CMD_NOT = 4'b1111;

    // Memory ops use a positive immediate offset with no writeback; bit 0 selects load.
    localparam logic [5:0] FUNCT_LDR = 6'b011001;
    localparam logic [5:0] FUNCT_STR = 6'b011000;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;
    localparam logic [1:0] BR_TAG = 2'b10;

    localparam int COND_LSB  = 28;
    localparam int OP_LSB    = 26;
    localparam int FUNCT_LSB = 20;
    localparam int BR_LSB    = 24;
    localparam int RN_LSB    = 16;
    localparam int RD_LSB    = 12;
    localparam int SRC2_LSB  = 0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCEPT = 2'b01,
        ST_WRITE  = 2'b10,
        ST_DONE   = 2'b11
    } state_e;

    function automatic logic dp_cmd_legal(input logic [3:0] cmd);
        return (cmd == CMD_ADD) || (cmd == CMD_SUB) ||
               (cmd == CMD_XOR) || (cmd == CMD_NOT);
    endfunction

endpackage

// File: rtl/instr_field_packer.sv
// rtl/instr_field_packer.sv - combinational packing of a decoded field bundle into one instruction word
module instr_field_packer
    import instr_enc_pkg::*;
(
    input  logic [1:0]  kind_i,
    input  logic [3:0]  cond_i,
    input  logic [3:0]  cmd_i,
    input  logic        s_i,
    input  logic        i_i,
    input  logic [3:0]  rn_i,
    input  logic [3:0]  rd_i,
    input  logic [11:0] src2_i,
    input  logic [23:0] imm24_i,
    output logic [31:0] word_o,
    output logic        legal_o
);

    always_comb begin
        word_o  = '0;
        legal_o = 1'b1;
        word_o[COND_LSB +: 4] = cond_i;
        case (kind_i)
            KIND_DP: begin
                word_o[OP_LSB +: 2]    = OP_DP;
                word_o[FUNCT_LSB +: 6] = {i_i, cmd_i, s_i};
                word_o[RN_LSB +: 4]    = rn_i;
                word_o[RD_LSB +: 4]    = rd_i;
                word_o[SRC2_LSB +: 12] = src2_i;
                legal_o                = dp_cmd_legal(cmd_i);
            end
            KIND_LDR, KIND_STR: begin
                word_o[OP_LSB +: 2]    = OP_MEM;
                word_o[FUNCT_LSB +: 6] = (kind_i == KIND_LDR) ? FUNCT_LDR : FUNCT_STR;
                word_o[RN_LSB +: 4]    = rn_i;
                word_o[RD_LSB +: 4]    = rd_i;
                word_o[SRC2_LSB +: 12] = src2_i;
            end
            default: begin
                // Branches carry only the offset; register and src2 fields are dropped.
                word_o[OP_LSB +: 2] = OP_BR;
                word_o[BR_LSB +: 2] = BR_TAG;
                word_o[23:0]        = imm24_i;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// rtl/instr_encoder_loader.sv - load-job FSM writing packed instruction words to consecutive memory addresses
module instr_encoder_loader
    import instr_enc_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int ADDR_STEP = ADDR_STEP_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  count,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_kind,
    input  logic [3:0]        in_cond,
    input  logic [3:0]        in_cmd,
    input  logic              in_s,
    input  logic              in_i,
    input  logic [3:0]        in_rn,
    input  logic [3:0]        in_rd,
    input  logic [11:0]       in_src2,
    input  logic [23:0]       in_imm24,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err_illegal,
    output logic [CNT_W-1:0]  written_count
);

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [31:0]        word_q, word_d;
    logic [CNT_W-1:0]   remaining_q, remaining_d;
    logic [CNT_W-1:0]   written_q, written_d;
    logic               err_q, err_d;

    logic [31:0]        enc_word;
    logic               enc_legal;
    logic               xfer;

    instr_field_packer u_packer (
        .kind_i  (in_kind),
        .cond_i  (in_cond),
        .cmd_i   (in_cmd),
        .s_i     (in_s),
        .i_i     (in_i),
        .rn_i    (in_rn),
        .rd_i    (in_rd),
        .src2_i  (in_src2),
        .imm24_i (in_imm24),
        .word_o  (enc_word),
        .legal_o (enc_legal)
    );

    assign xfer = in_valid && (state_q == ST_ACCEPT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            word_q      <= '0;
            remaining_q <= '0;
            written_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            word_q      <= word_d;
            remaining_q <= remaining_d;
            written_q   <= written_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        word_d      = word_q;
        remaining_d = remaining_q;
        written_d   = written_q;
        err_d       = err_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    addr_d      = base_addr;
                    remaining_d = count;
                    written_d   = '0;
                    err_d       = 1'b0;
                    state_d     = (count == '0) ? ST_DONE : ST_ACCEPT;
                end
            end
            ST_ACCEPT: begin
                if (xfer) begin
                    word_d      = enc_word;
                    remaining_d = remaining_q - CNT_W'(1);
                    if (enc_legal) begin
                        state_d = ST_WRITE;
                    end else begin
                        // Illegal bundles consume a slot but leave the address where it was.
                        err_d   = 1'b1;
                        state_d = (remaining_q == CNT_W'(1)) ? ST_DONE : ST_ACCEPT;
                    end
                end
            end
            ST_WRITE: begin
                addr_d    = addr_q + ADDR_W'(ADDR_STEP);
                written_d = written_q + CNT_W'(1);
                state_d   = (remaining_q == '0) ? ST_DONE : ST_ACCEPT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Strobes decode straight from the state register so an async reset drops them at once.
    assign in_ready      = (state_q == ST_ACCEPT);
    assign mem_we        = (state_q == ST_WRITE);
    assign busy          = (state_q != ST_IDLE);
    assign done          = (state_q == ST_DONE);
    assign mem_addr      = addr_q;
    assign mem_wdata     = word_q;
    assign err_illegal   = err_q;
    assign written_count = written_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb/tb_instr_encoder_loader.sv - directed vector bench for the instruction encoder/loader
module tb_instr_encoder_loader;

    logic        clk = 1'b0;
    logic        reset, start, in_valid, in_ready;
    logic [31:0] base_addr;
    logic [7:0]  count;
    logic [1:0]  in_kind;
    logic [3:0]  in_cond, in_cmd, in_rn, in_rd;
    logic        in_s, in_i;
    logic [11:0] in_src2;
    logic [23:0] in_imm24;
    logic        mem_we, busy, done, err_illegal;
    logic [31:0] mem_addr, mem_wdata;
    logic [7:0]  written_count;

    instr_encoder_loader dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .count(count),
        .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind), .in_cond(in_cond),
        .in_cmd(in_cmd), .in_s(in_s), .in_i(in_i), .in_rn(in_rn), .in_rd(in_rd),
        .in_src2(in_src2), .in_imm24(in_imm24), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .busy(busy), .done(done), .err_illegal(err_illegal),
        .written_count(written_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  kind;
        logic [3:0]  cond, cmd;
        logic        s, i;
        logic [3:0]  rn, rd;
        logic [11:0] src2;
        logic [23:0] imm24;
        logic [31:0] exp_word;
        logic        exp_legal;
    } vec_t;

    int errors = 0;
    int checks = 0;
    logic [31:0] wa[$];
    logic [31:0] wd[$];
    logic prev_we = 1'b0;
    vec_t vecs[11];

    always @(negedge clk) begin
        if (mem_we) begin
            checks++;
            if (prev_we) begin
                errors++;
                $display("FAIL we_width: mem_we high 2 cycles in a row at addr %0h, want 1-cycle pulse", mem_addr);
            end
            wa.push_back(mem_addr);
            wd.push_back(mem_wdata);
        end
        prev_we = mem_we;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, want completion");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input logic [1:0] k, input logic [3:0] c, input logic [3:0] cm,
                                input logic s, input logic i, input logic [3:0] rn,
                                input logic [3:0] rd, input logic [11:0] s2,
                                input logic [23:0] im, input logic [31:0] w, input logic lg);
        vec_t v;
        v.kind = k; v.cond = c; v.cmd = cm; v.s = s; v.i = i; v.rn = rn; v.rd = rd;
        v.src2 = s2; v.imm24 = im; v.exp_word = w; v.exp_legal = lg;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_start(input logic [31:0] b, input logic [7:0] c);
        start = 1'b1; base_addr = b; count = c;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input vec_t v);
        int n;
        in_kind = v.kind; in_cond = v.cond; in_cmd = v.cmd; in_s = v.s; in_i = v.i;
        in_rn = v.rn; in_rd = v.rd; in_src2 = v.src2; in_imm24 = v.imm24;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) chk("send_timeout", 64'd0, 64'd1);
        tick();
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!done && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) begin
            chk({tag, "_done_timeout"}, 64'd0, 64'd1);
        end else begin
            tick();
            chk({tag, "_done_1cyc"}, {63'd0, done}, 64'd0);
            chk({tag, "_idle"}, {63'd0, busy}, 64'd0);
        end
    endtask

    initial begin
        vec_t bad;
        logic [31:0] exp_a[4];
        logic [31:0] exp_d[4];

        vecs[0]  = mk(2'b00, 4'hE, 4'b0100, 1'b0, 1'b1, 4'h2, 4'h1, 12'h005, 24'h0, 32'hE2821005, 1'b1);
        vecs[1]  = mk(2'b00, 4'hE, 4'b0010, 1'b1, 1'b0, 4'h3, 4'h3, 12'h004, 24'h0, 32'hE0533004, 1'b1);
        vecs[2]  = mk(2'b01, 4'hE, 4'hA,    1'b1, 1'b1, 4'h1, 4'h0, 12'h008, 24'h0, 32'hE5910008, 1'b1);
        vecs[3]  = mk(2'b10, 4'hE, 4'h0,    1'b0, 1'b0, 4'h1, 4'h0, 12'h008, 24'h0, 32'hE5810008, 1'b1);
        vecs[4]  = mk(2'b11, 4'hE, 4'hA,    1'b1, 1'b1, 4'hF, 4'hF, 12'hFFF, 24'h000010, 32'hEA000010, 1'b1);
        vecs[5]  = mk(2'b00, 4'h0, 4'b0001, 1'b0, 1'b0, 4'h4, 4'h5, 12'h0AB, 24'h0, 32'h002450AB, 1'b1);
        vecs[6]  = mk(2'b00, 4'h1, 4'b1111, 1'b1, 1'b1, 4'h0, 4'h7, 12'hFFF, 24'h0, 32'h13F07FFF, 1'b1);
        vecs[7]  = mk(2'b00, 4'hE, 4'b0000, 1'b0, 1'b0, 4'h1, 4'h2, 12'h003, 24'h0, 32'h0, 1'b0);
        vecs[8]  = mk(2'b00, 4'hE, 4'b1010, 1'b0, 1'b1, 4'h1, 4'h2, 12'h003, 24'h0, 32'h0, 1'b0);
        vecs[9]  = mk(2'b11, 4'hB, 4'h0,    1'b0, 1'b0, 4'h0, 4'h0, 12'h000, 24'hABCDEF, 32'hBAABCDEF, 1'b1);
        vecs[10] = mk(2'b01, 4'h3, 4'h0,    1'b0, 1'b0, 4'hF, 4'hE, 12'h123, 24'h0, 32'h359FE123, 1'b1);

        reset = 1'b1; start = 1'b0; base_addr = '0; count = '0; in_valid = 1'b0;
        in_kind = '0; in_cond = '0; in_cmd = '0; in_s = 1'b0; in_i = 1'b0;
        in_rn = '0; in_rd = '0; in_src2 = '0; in_imm24 = '0;
        tick(); tick();
        chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
        chk("rst_mem_we", {63'd0, mem_we}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_err", {63'd0, err_illegal}, 64'd0);
        chk("rst_addr", {32'd0, mem_addr}, 64'd0);
        chk("rst_wdata", {32'd0, mem_wdata}, 64'd0);
        chk("rst_wcount", {56'd0, written_count}, 64'd0);
        reset = 1'b0;
        tick();

        // Single-bundle jobs from the vector table.
        for (int k = 0; k < 11; k++) begin
            wa.delete(); wd.delete();
            do_start(32'h100, 8'd1);
            send(vecs[k]);
            in_valid = 1'b0;
            wait_done($sformatf("vec%0d", k));
            chk($sformatf("vec%0d_nwr", k), 64'(wa.size()), vecs[k].exp_legal ? 64'd1 : 64'd0);
            if (vecs[k].exp_legal && wa.size() == 1) begin
                chk($sformatf("vec%0d_addr", k), {32'd0, wa[0]}, 64'h100);
                chk($sformatf("vec%0d_data", k), {32'd0, wd[0]}, {32'd0, vecs[k].exp_word});
            end
            chk($sformatf("vec%0d_err", k), {63'd0, err_illegal}, {63'd0, !vecs[k].exp_legal});
            chk($sformatf("vec%0d_wcnt", k), {56'd0, written_count}, {63'd0, vecs[k].exp_legal});
        end

        // Burst of four with in_valid held high throughout.
        wa.delete(); wd.delete();
        do_start(32'h100, 8'd4);
        for (int k = 1; k <= 4; k++) send(vecs[k]);
        in_valid = 1'b0;
        wait_done("burst");
        exp_a = '{32'h100, 32'h104, 32'h108, 32'h10C};
        exp_d = '{32'hE0533004, 32'hE5910008, 32'hE5810008, 32'hEA000010};
        chk("burst_nwr", 64'(wa.size()), 64'd4);
        for (int k = 0; k < 4 && k < wa.size(); k++) begin
            chk($sformatf("burst_addr%0d", k), {32'd0, wa[k]}, {32'd0, exp_a[k]});
            chk($sformatf("burst_data%0d", k), {32'd0, wd[k]}, {32'd0, exp_d[k]});
        end
        chk("burst_wcnt", {56'd0, written_count}, 64'd4);

        // Illegal bundle in the middle of a job.
        wa.delete(); wd.delete();
        do_start(32'h100, 8'd3);
        send(vecs[0]);
        send(vecs[8]);
        send(vecs[1]);
        in_valid = 1'b0;
        wait_done("illeg");
        chk("illeg_nwr", 64'(wa.size()), 64'd2);
        if (wa.size() == 2) begin
            chk("illeg_addr0", {32'd0, wa[0]}, 64'h100);
            chk("illeg_addr1", {32'd0, wa[1]}, 64'h104);
            chk("illeg_data1", {32'd0, wd[1]}, 64'hE0533004);
        end
        chk("illeg_err", {63'd0, err_illegal}, 64'd1);
        chk("illeg_wcnt", {56'd0, written_count}, 64'd2);

        // Zero-count job: done the cycle after start, error flag cleared, nothing written.
        wa.delete(); wd.delete();
        do_start(32'h300, 8'd0);
        chk("zero_done", {63'd0, done}, 64'd1);
        chk("zero_err_clr", {63'd0, err_illegal}, 64'd0);
        chk("zero_wcnt", {56'd0, written_count}, 64'd0);
        wait_done("zero");
        chk("zero_nwr", 64'(wa.size()), 64'd0);

        // Start pulsed mid-job must not disturb the running job.
        wa.delete(); wd.delete();
        do_start(32'h400, 8'd2);
        start = 1'b1; base_addr = 32'h800; count = 8'd1;
        tick();
        start = 1'b0;
        send(vecs[0]);
        send(vecs[5]);
        in_valid = 1'b0;
        wait_done("busy_start");
        chk("busy_start_nwr", 64'(wa.size()), 64'd2);
        if (wa.size() == 2) begin
            chk("busy_start_addr0", {32'd0, wa[0]}, 64'h400);
            chk("busy_start_addr1", {32'd0, wa[1]}, 64'h404);
        end
        chk("busy_start_wcnt", {56'd0, written_count}, 64'd2);

        // Asynchronous reset while the write strobe is active.
        do_start(32'h500, 8'd2);
        in_kind = vecs[0].kind; in_cond = vecs[0].cond; in_cmd = vecs[0].cmd;
        in_s = vecs[0].s; in_i = vecs[0].i; in_rn = vecs[0].rn; in_rd = vecs[0].rd;
        in_src2 = vecs[0].src2; in_imm24 = vecs[0].imm24;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("arst_in_write", {63'd0, mem_we}, 64'd1);
        #2 reset = 1'b1;
        #1;
        chk("arst_we_low", {63'd0, mem_we}, 64'd0);
        chk("arst_busy", {63'd0, busy}, 64'd0);
        chk("arst_addr", {32'd0, mem_addr}, 64'd0);
        tick();
        reset = 1'b0;
        tick();
        wa.delete(); wd.delete();
        do_start(32'h600, 8'd1);
        send(vecs[0]);
        in_valid = 1'b0;
        wait_done("arst_restart");
        chk("arst_restart_nwr", 64'(wa.size()), 64'd1);
        if (wa.size() == 1) begin
            chk("arst_restart_addr", {32'd0, wa[0]}, 64'h600);
            chk("arst_restart_data", {32'd0, wd[0]}, 64'hE2821005);
        end
        chk("arst_restart_wcnt", {56'd0, written_count}, 64'd1);

        // Address wrap at the top of the address space.
        wa.delete(); wd.delete();
        do_start(32'hFFFFFFFC, 8'd2);
        send(vecs[0]);
        send(vecs[9]);
        in_valid = 1'b0;
        wait_done("wrap");
        chk("wrap_nwr", 64'(wa.size()), 64'd2);
        if (wa.size() == 2) begin
            chk("wrap_addr0", {32'd0, wa[0]}, 64'hFFFFFFFC);
            chk("wrap_addr1", {32'd0, wa[1]}, 64'h0);
            chk("wrap_data1", {32'd0, wd[1]}, 64'hBAABCDEF);
        end
        chk("wrap_next_addr", {32'd0, mem_addr}, 64'h4);

        bad = vecs[7];
        wa.delete(); wd.delete();
        do_start(32'h700, 8'd1);
        send(bad);
        in_valid = 1'b0;
        wait_done("solo_illeg");
        chk("solo_illeg_addr_hold", {32'd0, mem_addr}, 64'h700);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
